// File: rtl/perceptron_backprop_if.sv
// Signal bundle between a perceptron training controller and the backprop engine.
// A sample moves on the rising edge where start_valid && start_ready. Once valid is raised, the sample is held until that edge.
`ifndef FP_WIDTH
`define FP_WIDTH 16
`endif

interface perceptron_backprop_if #(
   parameter int WIDTH = `FP_WIDTH,
   parameter int N     = 4
);
   logic                    load_en;
   logic signed [WIDTH-1:0] w_in [N];
   logic signed [WIDTH-1:0] b_in;
   logic                    start_valid;
   logic                    start_ready;
   logic signed [WIDTH-1:0] x [N];
   logic signed [WIDTH-1:0] z;
   logic signed [WIDTH-1:0] dy;
   logic signed [WIDTH-1:0] lr;
   logic signed [WIDTH-1:0] w_out [N];
   logic signed [WIDTH-1:0] b_out;
   logic signed [WIDTH-1:0] dx [N];
   logic                    busy;
   logic                    done;
   logic [2:0]              state_dbg;

   modport master (
      output load_en, w_in, b_in, start_valid, x, z, dy, lr,
      input  start_ready, w_out, b_out, dx, busy, done, state_dbg
   );
   modport slave (
      input  load_en, w_in, b_in, start_valid, x, z, dy, lr,
      output start_ready, w_out, b_out, dx, busy, done, state_dbg
   );
endinterface

// File: rtl/perceptron_backprop.sv
// Backward pass and SGD weight update for a single ReLU perceptron.
// The engine owns the weight and bias registers. It updates one element per cycle.
`ifndef FP_WIDTH
`define FP_WIDTH 16
`endif

module perceptron_backprop #(
   parameter int WIDTH = `FP_WIDTH,
   parameter int FRAC  = 8,
   parameter int N     = 4
) (
   input logic clk,
   input logic rst_n,
   perceptron_backprop_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_DELTA, S_UPDATE, S_BIAS, S_DONE} state_t;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [2*WIDTH:0] v);
      logic signed [2*WIDTH:0] hi;
      logic signed [2*WIDTH:0] lo;
      hi = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
      lo = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
      if (v > hi)      sat = hi[WIDTH-1:0];
      else if (v < lo) sat = lo[WIDTH-1:0];
      else             sat = v[WIDTH-1:0];
   endfunction

   state_t                  state, state_nx;
   logic [IW-1:0]           idx;
   logic signed [WIDTH-1:0] x_r [N];
   logic signed [WIDTH-1:0] z_r, dy_r, lr_r, d_r, step_r, b_r;
   logic signed [WIDTH-1:0] w_r [N];
   logic signed [WIDTH-1:0] dx_r [N];
   logic                    done_r;

   logic                      accept, load_take;
   logic signed [WIDTH-1:0]   d_next, step_next, w_cur, dx_next, upd, w_new, b_new;
   logic signed [2*WIDTH-1:0] step_prod, dx_prod, upd_prod;
   logic signed [WIDTH:0]     w_diff, b_diff;

   // done is registered one cycle after the DONE state, so start_ready stays low until the cycle after done.
   assign load_take       = (state == S_IDLE) && bus.load_en;
   assign bus.start_ready = (state == S_IDLE) && !bus.load_en && !done_r;
   assign accept          = bus.start_valid && bus.start_ready;
   assign bus.busy        = (state != S_IDLE);
   assign bus.done        = done_r;
   assign bus.state_dbg   = 3'(state);
   assign bus.w_out       = w_r;
   assign bus.b_out       = b_r;
   assign bus.dx          = dx_r;

   always_comb begin
      d_next    = (z_r > 0) ? dy_r : '0;
      step_prod = lr_r * d_next;
      step_next = sat(step_prod >>> FRAC);
      w_cur     = w_r[idx];
      dx_prod   = d_r * w_cur;
      dx_next   = sat(dx_prod >>> FRAC);
      upd_prod  = step_r * x_r[idx];
      upd       = sat(upd_prod >>> FRAC);
      w_diff    = w_cur - upd;
      w_new     = sat(w_diff);
      b_diff    = b_r - step_r;
      b_new     = sat(b_diff);
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (accept) state_nx = S_DELTA;
         S_DELTA:  state_nx = S_UPDATE;
         S_UPDATE: if (idx == IW'(N-1)) state_nx = S_BIAS;
         S_BIAS:   state_nx = S_DONE;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= '0;
         z_r    <= '0;
         dy_r   <= '0;
         lr_r   <= '0;
         d_r    <= '0;
         step_r <= '0;
         b_r    <= '0;
         done_r <= 1'b0;
         for (int i = 0; i < N; i++) begin
            x_r[i]  <= '0;
            w_r[i]  <= '0;
            dx_r[i] <= '0;
         end
      end else begin
         done_r <= (state == S_DONE);
         case (state)
            S_IDLE: begin
               if (load_take) begin
                  w_r <= bus.w_in;
                  b_r <= bus.b_in;
               end else if (accept) begin
                  x_r  <= bus.x;
                  z_r  <= bus.z;
                  dy_r <= bus.dy;
                  lr_r <= bus.lr;
                  idx  <= '0;
               end
            end
            S_DELTA: begin
               d_r    <= d_next;
               step_r <= step_next;
            end
            S_UPDATE: begin
               // dx uses the weight value from before this cycle's update.
               dx_r[idx] <= dx_next;
               w_r[idx]  <= w_new;
               idx       <= idx + IW'(1);
            end
            S_BIAS:  b_r <= b_new;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_perceptron_backprop.sv
// Self-checking bench for perceptron_backprop, using a behavioural model and an expected-value queue.
module tb_perceptron_backprop;
   localparam int W    = 16;
   localparam int FRAC = 8;
   localparam int N    = 4;
   localparam int LAT  = N + 3;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   int   m_w [N];
   int   m_b;
   logic [W-1:0] exp_q[$];

   perceptron_backprop_if #(.WIDTH(W), .N(N)) bus ();

   perceptron_backprop #(.WIDTH(W), .FRAC(FRAC), .N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
      else n_pass++;
   endtask

   function automatic int sat(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   task automatic do_load(input int ws [N], input int b);
      @(negedge clk);
      bus.load_en = 1'b1;
      for (int i = 0; i < N; i++) bus.w_in[i] = W'(ws[i]);
      bus.b_in = W'(b);
      @(posedge clk);
      #1 bus.load_en = 1'b0;
      for (int i = 0; i < N; i++) m_w[i] = ws[i];
      m_b = b;
   endtask

   task automatic run_sample(input string tag, input int xs [N], input int z, input int dy,
                             input int lr, input bit hold);
      int d, step, lat;
      int dxv [N];
      bit got;
      d    = (z > 0) ? dy : 0;
      step = sat((longint'(lr) * longint'(d)) >>> FRAC);
      for (int i = 0; i < N; i++) begin
         dxv[i] = sat((longint'(d) * longint'(m_w[i])) >>> FRAC);
         m_w[i] = sat(longint'(m_w[i]) - sat((longint'(step) * longint'(xs[i])) >>> FRAC));
      end
      m_b = sat(longint'(m_b) - step);
      for (int i = 0; i < N; i++) exp_q.push_back(W'(m_w[i]));
      exp_q.push_back(W'(m_b));
      for (int i = 0; i < N; i++) exp_q.push_back(W'(dxv[i]));

      @(negedge clk);
      check({tag, ".ready"}, W'(bus.start_ready), W'(1));
      for (int i = 0; i < N; i++) bus.x[i] = W'(xs[i]);
      bus.z  = W'(z);
      bus.dy = W'(dy);
      bus.lr = W'(lr);
      bus.start_valid = 1'b1;
      @(posedge clk);
      #1;
      if (hold) begin
         bus.load_en = 1'b1;
         for (int i = 0; i < N; i++) bus.w_in[i] = W'(1000);
         bus.b_in = W'(1000);
      end else begin
         bus.start_valid = 1'b0;
      end
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (hold && lat == 3) begin
            check({tag, ".busy_mid"}, W'(bus.busy), W'(1));
            check({tag, ".ready_mid"}, W'(bus.start_ready), W'(0));
         end
         got = bus.done;
      end
      bus.load_en     = 1'b0;
      bus.start_valid = 1'b0;
      check({tag, ".latency"}, W'(lat), W'(LAT));
      for (int i = 0; i < N; i++) check($sformatf("%s.w%0d", tag, i), bus.w_out[i], exp_q.pop_front());
      check({tag, ".b"}, bus.b_out, exp_q.pop_front());
      for (int i = 0; i < N; i++) check($sformatf("%s.dx%0d", tag, i), bus.dx[i], exp_q.pop_front());
   endtask

   initial begin
      int ones [N];
      int dones;
      n_checks = 0;
      n_pass   = 0;
      for (int i = 0; i < N; i++) ones[i] = 256;
      rst_n = 1'b0;
      bus.load_en = 1'b0;
      bus.start_valid = 1'b0;
      bus.b_in = '0;
      bus.z = '0;
      bus.dy = '0;
      bus.lr = '0;
      for (int i = 0; i < N; i++) begin
         bus.w_in[i] = '0;
         bus.x[i]    = '0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         check($sformatf("rst.w%0d", i), bus.w_out[i], W'(0));
         check($sformatf("rst.dx%0d", i), bus.dx[i], W'(0));
      end
      check("rst.b", bus.b_out, W'(0));
      check("rst.ready", W'(bus.start_ready), W'(1));
      check("rst.busy", W'(bus.busy), W'(0));
      check("rst.done", W'(bus.done), W'(0));
      for (int i = 0; i < N; i++) m_w[i] = 0;
      m_b = 0;

      // Basic update, checked against hand-derived constants as well as the model
      do_load('{256, 512, -256, 0}, 128);
      run_sample("basic", ones, 100, 256, 128, 1'b0);
      check("basic.k_w0", bus.w_out[0], W'(128));
      check("basic.k_w2", bus.w_out[2], W'(-384));
      check("basic.k_w3", bus.w_out[3], W'(-128));
      check("basic.k_dx1", bus.dx[1], W'(512));

      // Inactive neuron: negative and zero pre-activation
      do_load('{256, 512, -256, 0}, 128);
      run_sample("inact_neg", ones, -5, 256, 128, 1'b0);
      check("inact_neg.k_w1", bus.w_out[1], W'(512));
      run_sample("inact_zero", ones, 0, 256, 128, 1'b0);
      check("inact_zero.k_b", bus.b_out, W'(128));

      // Zero learning rate still yields dx
      run_sample("lr0", ones, 50, 512, 0, 1'b0);
      check("lr0.k_dx1", bus.dx[1], W'(1024));

      // Saturation
      do_load('{-32768, 0, 0, 0}, 0);
      run_sample("sat", '{32767, 0, 0, 0}, 1, 32767, 256, 1'b0);
      check("sat.k_w0", bus.w_out[0], W'(-32768));
      check("sat.k_dx0", bus.dx[0], W'(-32768));
      check("sat.k_b", bus.b_out, W'(-32767));

      // Busy protection: start_valid and load_en held during an update
      do_load('{256, 512, -256, 0}, 128);
      run_sample("hold", ones, 100, 256, 128, 1'b1);
      repeat (2) @(negedge clk);
      check("hold.busy_after", W'(bus.busy), W'(0));
      check("hold.w0_after", bus.w_out[0], W'(m_w[0]));
      check("hold.b_after", bus.b_out, W'(m_b));

      // load_en and start_valid together in IDLE: the load wins
      @(negedge clk);
      bus.load_en = 1'b1;
      bus.start_valid = 1'b1;
      for (int i = 0; i < N; i++) bus.w_in[i] = W'(11 * (i + 1));
      bus.b_in = W'(55);
      #1 check("both.ready", W'(bus.start_ready), W'(0));
      @(posedge clk);
      #1;
      bus.load_en = 1'b0;
      bus.start_valid = 1'b0;
      @(negedge clk);
      check("both.busy", W'(bus.busy), W'(0));
      check("both.w0", bus.w_out[0], W'(11));
      check("both.w3", bus.w_out[3], W'(44));
      check("both.b", bus.b_out, W'(55));
      for (int i = 0; i < N; i++) m_w[i] = 11 * (i + 1);
      m_b = 55;

      // Random samples against the model
      for (int t = 0; t < 6; t++) begin
         int xs [N];
         int ws [N];
         for (int i = 0; i < N; i++) begin
            ws[i] = int'($urandom_range(0, 16000)) - 8000;
            xs[i] = int'($urandom_range(0, 8000)) - 4000;
         end
         do_load(ws, int'($urandom_range(0, 4000)) - 2000);
         run_sample($sformatf("rnd%0d", t), xs, int'($urandom_range(0, 200)) - 100,
                    int'($urandom_range(0, 12000)) - 6000, int'($urandom_range(0, 400)), 1'b0);
      end

      // Reset in the middle of UPDATE at element 2
      do_load('{300, 400, 500, 600}, 70);
      @(negedge clk);
      for (int i = 0; i < N; i++) bus.x[i] = W'(256);
      bus.z  = W'(10);
      bus.dy = W'(256);
      bus.lr = W'(256);
      bus.start_valid = 1'b1;
      @(posedge clk);
      #1 bus.start_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst.w0", bus.w_out[0], W'(0));
      check("midrst.w3", bus.w_out[3], W'(0));
      check("midrst.b", bus.b_out, W'(0));
      check("midrst.busy", W'(bus.busy), W'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("midrst.no_done", W'(dones), W'(0));
      check("midrst.ready", W'(bus.start_ready), W'(1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
